gshare_pht: RTL
===============

# gshare_pht

Pattern history table for the gshare branch predictor. Sits directly downstream of the 8-bit global history register: each lookup XORs the fetch PC with the current global history to index a table of 2-bit saturating counters, and returns a registered taken/not-taken prediction plus the index used. Resolved branches write back through a separate update port that trains the indexed counter. The same resolved outcome also drives the history register's `update`/`taken` inputs.

## Interface
- `INDEX_W`, 8: table index width; table depth = 2^INDEX_W. Must equal the history width (8).
- `PC_W`, 32: fetch PC width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ghr` in 8: current global history from the history register.
- `lk_valid` in 1: lookup request this cycle.
- `lk_pc` in PC_W: PC of the branch being looked up.
- `pred_valid` out 1: prediction is valid, one cycle after `lk_valid`.
- `pred_taken` out 1: predicted direction (counter MSB).
- `pred_index` out INDEX_W: index used for this prediction; carried with the branch to resolution.
- `upd_valid` in 1: resolved-branch update this cycle.
- `upd_index` in INDEX_W: index returned by the original prediction.
- `upd_taken` in 1: actual outcome.
- `upd_mispredict` in 1: the prediction for this branch was wrong.
- `mispred_cnt` out 16: saturating count of updates with `upd_mispredict=1`.

## Operation
- Index = `lk_pc[INDEX_W+1:2]` XOR `ghr`. PC bits [1:0] are ignored.
- Table: 2^INDEX_W two-bit counters. Encodings are SNT=00, WNT=01, WT=10, ST=11.
- Prediction: `pred_taken` = MSB of the indexed counter.
- Update when `upd_valid`:
  - `upd_taken=1`: counter +1, saturating at 11.
  - `upd_taken=0`: counter −1, saturating at 00.
  - Counters not addressed are unchanged.
- Same-cycle read/write to the same index: the lookup returns the pre-update value. No forwarding.
- Lookup and update to different indices in the same cycle both take effect.
- `mispred_cnt` increments on each `upd_valid & upd_mispredict`. It saturates at 16'hFFFF and never wraps.
- With `lk_valid=0`, `pred_valid` deasserts next cycle. `pred_taken` and `pred_index` hold their last values.
- Reset (asynchronous, any time, including mid-update):
  - every counter → WNT (01)
  - `pred_valid`=0, `pred_taken`=0, `pred_index`=0
  - `mispred_cnt`=0
  - An update coincident with reset is dropped.

## Timing
- Lookup latency is 1 cycle. `lk_*` sampled at edge N gives `pred_*` valid after edge N, held until edge N+1.
- Update is written at the sampling edge and is visible to lookups sampled at edge N+1 onward.
- `mispred_cnt` reflects an update one edge after `upd_valid`.
- Back-to-back lookups and updates are accepted every cycle. There is no backpressure and no stall input.
- The history register updates at the same edge as `upd_valid`. A lookup sampled at that edge uses the pre-shift `ghr`.

## Structure
- The shared package `bp_pkg` holds:
  - `ctr2_t` typedef
  - `CTR_SNT`/`CTR_WNT`/`CTR_WT`/`CTR_ST` constants
  - `CTR_RESET = CTR_WNT`
  - `GHR_W = 8`
- The table is implemented as flops, because the asynchronous reset clears all entries; it is not an SRAM macro.
- One sub-module, `bp_sat_ctr2`: purely combinational next-state function (ctr, taken) → ctr. It is shared with future local/bimodal tables.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle. Then look up PC=0x0000_0000 with ghr=0x00 → `pred_valid`=1 next cycle, `pred_taken`=0, `pred_index`=0x00, `mispred_cnt`=0.
- Index hash: PC=0x0000_03FC with ghr=0xA5 → `pred_index`=0xFF^0xA5=0x5A. PC=0x0000_0403 with ghr=0x00 → `pred_index`=0x00.
- Saturation: three taken updates to index 0x10 → lookups give taken. Then one not-taken → still taken (WT). Second not-taken → not-taken (WNT). Five more not-taken → counter stays SNT, no wrap.
- Read/write collision: index 0x20 is at WNT. Same cycle: `upd_valid` taken to 0x20 and lookup of 0x20 → `pred_taken`=0. The lookup one cycle later → `pred_taken`=1.
- Misprediction counter: 70000 updates with `upd_mispredict=1` → `mispred_cnt`=0xFFFF, holds. Reset → 0.
- Reset mid-operation: train index 0x33 to ST, assert `rst` during an update cycle → lookup of 0x33 after release returns not-taken (WNT), `mispred_cnt`=0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-predictor types and constants.
package bp_pkg;

  // Two-bit saturating direction counter.
  typedef logic [1:0] ctr2_t;

  localparam ctr2_t CTR_SNT   = 2'b00;
  localparam ctr2_t CTR_WNT   = 2'b01;
  localparam ctr2_t CTR_WT    = 2'b10;
  localparam ctr2_t CTR_ST    = 2'b11;
  localparam ctr2_t CTR_RESET = CTR_WNT;

  // Global history register width; the gshare index must match it.
  localparam int GHR_W = 8;

endpackage : bp_pkg

// File: rtl/bp_sat_ctr2.sv
// Next-state function for a 2-bit saturating counter (shared by PHT-style tables).
module bp_sat_ctr2
  import bp_pkg::*;
(
  input  ctr2_t ctr_i,
  input  logic  taken_i,
  output ctr2_t ctr_o
);

  // Step toward taken/not-taken, clamping at the ends.
  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'b01;
    end else begin
      if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'b01;
    end
  end

endmodule : bp_sat_ctr2

// File: rtl/gshare_pht.sv
// gshare pattern history table: PC^GHR-indexed 2-bit counters with a
// registered lookup port, a training port and a saturating mispredict counter.
// The table lives in flops so the asynchronous reset can clear every entry.
module gshare_pht
  import bp_pkg::*;
#(
  parameter int INDEX_W = 8,
  parameter int PC_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [GHR_W-1:0]   ghr,
  input  logic               lk_valid,
  input  logic [PC_W-1:0]    lk_pc,
  output logic               pred_valid,
  output logic               pred_taken,
  output logic [INDEX_W-1:0] pred_index,
  input  logic               upd_valid,
  input  logic [INDEX_W-1:0] upd_index,
  input  logic               upd_taken,
  input  logic               upd_mispredict,
  output logic [15:0]        mispred_cnt
);

  localparam int DEPTH = 1 << INDEX_W;

  ctr2_t              tbl_q [DEPTH];
  ctr2_t              upd_ctr_d;
  logic [INDEX_W-1:0] lk_idx;

  logic               pred_valid_q;
  logic               pred_taken_q;
  logic [INDEX_W-1:0] pred_index_q;
  logic [15:0]        mispred_cnt_q;
  logic [15:0]        mispred_cnt_d;

  // PC bits [1:0] are word-offset bits and carry no branch identity.
  assign lk_idx = lk_pc[INDEX_W+1:2] ^ ghr;

  bp_sat_ctr2 u_sat_ctr2 (
    .ctr_i   (tbl_q[upd_index]),
    .taken_i (upd_taken),
    .ctr_o   (upd_ctr_d)
  );

  // Counter table: train the addressed entry; reset drops any coincident update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= CTR_RESET;
    end else if (upd_valid) begin
      tbl_q[upd_index] <= upd_ctr_d;
    end
  end

  // Registered prediction; reads the pre-update table, so a same-cycle
  // write to the same index is not forwarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_index_q <= '0;
    end else begin
      pred_valid_q <= lk_valid;
      if (lk_valid) begin
        pred_taken_q <= tbl_q[lk_idx][1];
        pred_index_q <= lk_idx;
      end
    end
  end

  // Mispredict counter next state: saturate at all-ones, never wrap.
  always_comb begin
    mispred_cnt_d = mispred_cnt_q;
    if (upd_valid && upd_mispredict && (mispred_cnt_q != 16'hFFFF))
      mispred_cnt_d = mispred_cnt_q + 16'd1;
  end

  // Mispredict counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mispred_cnt_q <= '0;
    else     mispred_cnt_q <= mispred_cnt_d;
  end

  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign pred_index  = pred_index_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule : gshare_pht
